// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph table shared by the seven-segment encoder and capture logic
package seg7_pkg;
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_GLYPHS [16] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
        SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
    };
endpackage

// File: rtl/seg7_capture_if.sv
// seg7_capture_if: display bus snoop inputs and decoded readback outputs
interface seg7_capture_if #(parameter int NUM_DIGITS = 4);
    logic [NUM_DIGITS-1:0] an;
    logic [6:0] seg;
    logic clear;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0] digit_ok;
    logic frame_valid;
    logic err;
    modport master (output an, seg, clear, input value, digit_ok, frame_valid, err);
    modport slave (input an, seg, clear, output value, digit_ok, frame_valid, err);
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: active-low segment pattern to hex nibble
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       legal,
    output logic       blank
);
    assign blank = seg == SEG_BLANK;
    always_comb begin
        nibble = '0;
        legal = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (seg == SEG_GLYPHS[k]) begin
                nibble = 4'(k);
                legal = 1'b1;
            end
        end
    end
endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: snoops a multiplexed 7-segment bus and reconstructs per-digit hex values
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    seg7_capture_if.slave bus
);
    localparam int W  = NUM_DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [W-1:0] s1, s2, hold;
    logic [CW-1:0] cnt;
    logic [NUM_DIGITS-1:0] sel, seen, digit_ok;
    logic [4*NUM_DIGITS-1:0] value;
    logic frame_valid, err;
    logic [3:0] nibble;
    logic legal, blank, commit, one, multi;

    assign sel    = ~s2[W-1:7];
    assign one    = sel != '0 && (sel & (sel - NUM_DIGITS'(1))) == '0;
    assign multi  = sel != '0 && !one;
    // fires only on the cycle the counter steps up to STABLE_CYCLES
    assign commit = s2 == hold && cnt == CW'(STABLE_CYCLES - 1);

    seg7_decode u_dec (
        .seg    (s2[6:0]),
        .nibble (nibble),
        .legal  (legal),
        .blank  (blank)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1          <= '1;
            s2          <= '1;
            hold        <= '1;
            cnt         <= '0;
            seen        <= '0;
            value       <= '0;
            digit_ok    <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            s1          <= {bus.an, bus.seg};
            s2          <= s1;
            hold        <= s2;
            cnt         <= s2 != hold ? '0 : cnt == CW'(STABLE_CYCLES) ? cnt : cnt + CW'(1);
            frame_valid <= 1'b0;
            err         <= 1'b0;
            if (bus.clear) begin
                value    <= '0;
                digit_ok <= '0;
                seen     <= '0;
            end else if (commit && multi) begin
                err <= 1'b1;
            end else if (commit && one) begin
                err         <= !legal && !blank;
                frame_valid <= (seen | sel) == '1;
                seen        <= (seen | sel) == '1 ? '0 : seen | sel;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel[i]) begin
                        digit_ok[i] <= legal;
                        if (legal) value[4*i +: 4] <= nibble;
                    end
                end
            end
        end
    end

    assign bus.value       = value;
    assign bus.digit_ok    = digit_ok;
    assign bus.frame_valid = frame_valid;
    assign bus.err         = err;
endmodule
